pipe_skid_stage: RTL and testbench

- Pipeline stage register with a valid/ready handshake on both sides and a two-entry skid buffer.
- It is the consumer end of the stall path: it accepts data from an upstream stage and produces the hold/advance decision from the downstream ready.
- It sits between CPU pipeline stages (e.g. IF/ID, ID/EX) and gives full throughput with no combinational ready path.
- It supports a synchronous flush for branch mispredicts.

---
 rtl/pipe_pkg.sv | 12 +
 rtl/pipe_data_reg.sv | 34 +++
 rtl/pipe_skid_stage.sv | 145 ++++++++++++++
 tb/tb_pipe_skid_stage.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and widths for the pipeline skid stage.
package pipe_pkg;

    localparam int unsigned OCC_W = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

endpackage : pipe_pkg

// File: rtl/pipe_data_reg.sv
// Payload register with load enable and async active-low clear.
module pipe_data_reg #(
    parameter int unsigned SZ = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [SZ-1:0] d,
    output logic [SZ-1:0] q
);

    logic [SZ-1:0] data_q;
    logic [SZ-1:0] data_d;

    // Load new payload only when enabled, otherwise hold.
    always_comb begin
        data_d = data_q;
        if (en) begin
            data_d = d;
        end
    end

    // Payload storage, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule : pipe_data_reg

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with a two-entry skid buffer and synchronous flush.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int unsigned SZ = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SZ-1:0]    in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SZ-1:0]    out_data,
    output logic [OCC_W-1:0] occupancy
);

    skid_state_t      state_q;
    skid_state_t      state_d;
    logic             out_valid_q;
    logic             out_valid_d;
    logic             in_ready_q;
    logic             in_ready_d;
    logic [OCC_W-1:0] occupancy_q;
    logic [OCC_W-1:0] occupancy_d;

    logic             in_fire;
    logic             out_fire;
    logic             main_en;
    logic             skid_en;
    logic             main_from_skid;
    logic [SZ-1:0]    main_d;
    logic [SZ-1:0]    main_q;
    logic [SZ-1:0]    skid_q;

    // Handshakes use only registered status, so no combinational ready path.
    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    // Next state, register load enables and registered status decode.
    always_comb begin
        state_d        = state_q;
        main_en        = 1'b0;
        skid_en        = 1'b0;
        main_from_skid = 1'b0;
        out_valid_d    = 1'b0;
        in_ready_d     = 1'b1;
        occupancy_d    = OCC_W'(0);

        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d = BUSY;
                    main_en = 1'b1;
                end
            end
            BUSY: begin
                if (in_fire && out_fire) begin
                    main_en = 1'b1;
                end else if (in_fire) begin
                    state_d = FULL;
                    skid_en = 1'b1;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_d        = BUSY;
                    main_en        = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase

        // Flush wins: drop everything held, keep data registers untouched.
        if (flush) begin
            state_d = EMPTY;
            main_en = 1'b0;
            skid_en = 1'b0;
        end

        case (state_d)
            BUSY: begin
                out_valid_d = 1'b1;
                in_ready_d  = 1'b1;
                occupancy_d = OCC_W'(1);
            end
            FULL: begin
                out_valid_d = 1'b1;
                in_ready_d  = 1'b0;
                occupancy_d = OCC_W'(2);
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                occupancy_d = OCC_W'(0);
            end
        endcase
    end

    // Main register source: refill from skid when draining FULL.
    assign main_d = main_from_skid ? skid_q : in_data;

    // State and status registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            occupancy_q <= OCC_W'(0);
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            occupancy_q <= occupancy_d;
        end
    end

    pipe_data_reg #(.SZ(SZ)) u_main (
        .clk   (clk),
        .rst_n (reset_n),
        .en    (main_en),
        .d     (main_d),
        .q     (main_q)
    );

    pipe_data_reg #(.SZ(SZ)) u_skid (
        .clk   (clk),
        .rst_n (reset_n),
        .en    (skid_en),
        .d     (in_data),
        .q     (skid_q)
    );

    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;
    assign occupancy = occupancy_q;
    assign out_data  = main_q;

endmodule : pipe_skid_stage

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage against a queue-based reference model.
module tb_pipe_skid_stage;

    localparam int unsigned SZ = 64;

    logic          clk;
    logic          reset_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [SZ-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [SZ-1:0] out_data;
    logic [1:0]    occupancy;

    int n_cmp;
    int n_err;

    // Reference model: FIFO of held entries plus the last value seen at the head.
    logic [SZ-1:0] mq[$];
    logic [SZ-1:0] last_front;

    pipe_skid_stage #(.SZ(SZ)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        mq.delete();
        last_front = '0;
    endtask

    // Drive one cycle of inputs, advance the model, then settle past the edge.
    task automatic step(input logic iv, input logic [SZ-1:0] id, input logic ordy, input logic fl);
        bit ifire;
        bit ofire;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        ifire = iv && (mq.size() < 2);
        ofire = ordy && (mq.size() > 0);
        if (fl) begin
            mq.delete();
        end else begin
            if (ofire) void'(mq.pop_front());
            if (ifire) mq.push_back(id);
        end
        if (mq.size() > 0) last_front = mq[0];
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset out_valid got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset in_ready got %b want 1", in_ready); end
        n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL reset occupancy got %0d want 0", occupancy); end
        n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL reset out_data got %h want 0", out_data); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_streaming();
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, SZ'(i), 1'b1, 1'b0);
            n_cmp++; if (out_data !== SZ'(i)) begin n_err++; $display("FAIL stream data[%0d] got %h want %h", i, out_data, SZ'(i)); end
            n_cmp++; if (in_ready !== 1'b1 || occupancy !== 2'd1 || out_valid !== 1'b1) begin
                n_err++; $display("FAIL stream status[%0d] got rdy=%b occ=%0d vld=%b want 1/1/1", i, in_ready, occupancy, out_valid);
            end
        end
        step(1'b0, '0, 1'b1, 1'b0);
        n_cmp++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin n_err++; $display("FAIL stream drain got vld=%b occ=%0d want 0/0", out_valid, occupancy); end
    endtask

    task automatic test_skid();
        step(1'b1, SZ'('hA5), 1'b0, 1'b0);
        step(1'b1, SZ'('h5A), 1'b0, 1'b0);
        n_cmp++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin n_err++; $display("FAIL skid full got occ=%0d rdy=%b want 2/0", occupancy, in_ready); end
        n_cmp++; if (out_data !== SZ'('hA5)) begin n_err++; $display("FAIL skid head got %h want a5", out_data); end
        step(1'b1, SZ'('hFF), 1'b0, 1'b0);
        n_cmp++; if (out_data !== SZ'('hA5) || occupancy !== 2'd2) begin n_err++; $display("FAIL skid hold got %h occ=%0d want a5/2", out_data, occupancy); end
        step(1'b0, '0, 1'b1, 1'b0);
        n_cmp++; if (out_data !== SZ'('h5A) || occupancy !== 2'd1 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL skid second got %h occ=%0d rdy=%b want 5a/1/1", out_data, occupancy, in_ready);
        end
        step(1'b0, '0, 1'b1, 1'b0);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL skid empty got vld=%b want 0", out_valid); end
    endtask

    task automatic test_flush();
        step(1'b1, SZ'('h11), 1'b0, 1'b0);
        step(1'b1, SZ'('h22), 1'b0, 1'b0);
        step(1'b1, SZ'('hDEAD), 1'b0, 1'b1);
        n_cmp++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL flush status got occ=%0d vld=%b rdy=%b want 0/0/1", occupancy, out_valid, in_ready);
        end
        n_cmp++; if (out_data !== SZ'('h11)) begin n_err++; $display("FAIL flush retain got %h want 11", out_data); end
        step(1'b0, '0, 1'b1, 1'b0);
        n_cmp++; if (out_valid !== 1'b0 || out_data === SZ'('hDEAD)) begin
            n_err++; $display("FAIL flush discard got vld=%b data=%h want 0/not dead", out_valid, out_data);
        end
    endtask

    task automatic test_simultaneous();
        step(1'b1, SZ'(7), 1'b0, 1'b0);
        n_cmp++; if (out_data !== SZ'(7) || occupancy !== 2'd1) begin n_err++; $display("FAIL simul load got %h occ=%0d want 7/1", out_data, occupancy); end
        step(1'b1, SZ'(8), 1'b1, 1'b0);
        n_cmp++; if (out_data !== SZ'(8) || occupancy !== 2'd1 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL simul swap got %h occ=%0d rdy=%b want 8/1/1", out_data, occupancy, in_ready);
        end
        step(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_async_reset();
        step(1'b1, SZ'('h33), 1'b0, 1'b0);
        step(1'b1, SZ'('h44), 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || occupancy !== 2'd0 || out_data !== '0) begin
            n_err++; $display("FAIL async_reset got vld=%b rdy=%b occ=%0d data=%h want 0/1/0/0", out_valid, in_ready, occupancy, out_data);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step(1'b0, '0, 1'b1, 1'b0);
        n_cmp++; if (out_valid !== 1'b0 || out_data !== '0) begin
            n_err++; $display("FAIL async_release got vld=%b data=%h want 0/0", out_valid, out_data);
        end
        step(1'b1, SZ'('h55), 1'b1, 1'b0);
        n_cmp++; if (out_valid !== 1'b1 || out_data !== SZ'('h55)) begin
            n_err++; $display("FAIL async_first got vld=%b data=%h want 1/55", out_valid, out_data);
        end
        step(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic [SZ-1:0] d;
        logic [SZ-1:0] exp_data;
        for (int i = 0; i < 400; i++) begin
            d = {$urandom(), $urandom()};
            step(1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
            exp_data = (mq.size() > 0) ? mq[0] : last_front;
            n_cmp++; if (occupancy !== 2'(mq.size())) begin n_err++; $display("FAIL rand occupancy[%0d] got %0d want %0d", i, occupancy, mq.size()); end
            n_cmp++; if (out_valid !== (mq.size() > 0)) begin n_err++; $display("FAIL rand out_valid[%0d] got %b want %b", i, out_valid, mq.size() > 0); end
            n_cmp++; if (in_ready !== (mq.size() < 2)) begin n_err++; $display("FAIL rand in_ready[%0d] got %b want %b", i, in_ready, mq.size() < 2); end
            n_cmp++; if (out_data !== exp_data) begin n_err++; $display("FAIL rand out_data[%0d] got %h want %h", i, out_data, exp_data); end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset_n = 1'b1;
        #1;
        test_reset();
        test_streaming();
        test_skid();
        test_flush();
        test_simultaneous();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_pipe_skid_stage
